// File: rtl/control_unit.sv
// Hardwired microsequencer producing the control word for the accumulator CPU datapath.
// Optional single-step pausing between instructions: define CONTROL_UNIT_SINGLE_STEP_EN.
module control_unit #(
    parameter bit          ILLEGAL_HALT = 1'b0,
    parameter int unsigned CW_WIDTH     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    input  logic                step_i,
`endif
    input  logic [7:0]          opcode_i,
    input  logic                acc_neg_i,
    output logic [CW_WIDTH-1:0] control_signal_o,
    output logic [3:0]          state_o,
    output logic                halted_o,
    output logic                illegal_op_o
);

    typedef enum logic [3:0] {
        StBoot   = 4'd0,
        StFetch1 = 4'd1,
        StFetch2 = 4'd2,
        StFetch3 = 4'd3,
        StDecode = 4'd4,
        StEx1    = 4'd5,
        StEx2    = 4'd6,
        StEx3    = 4'd7,
        StHalt   = 4'd8,
        StPause  = 4'd9
    } state_e;

    localparam logic [7:0] OpStore  = 8'h01;
    localparam logic [7:0] OpLoad   = 8'h02;
    localparam logic [7:0] OpAdd    = 8'h03;
    localparam logic [7:0] OpSub    = 8'h04;
    localparam logic [7:0] OpJmpgez = 8'h05;
    localparam logic [7:0] OpJmp    = 8'h06;
    localparam logic [7:0] OpHalt   = 8'h07;

    localparam int CPcInc  = 0;
    localparam int CMarPc  = 1;
    localparam int CMarMbr = 2;
    localparam int CMbrMem = 3;
    localparam int CIrMbr  = 4;
    localparam int CPcMbr  = 5;
    localparam int CBrMbr  = 6;
    localparam int CAccAdd = 8;
    localparam int CAccSub = 9;
    localparam int CAccBr  = 10;
    localparam int CMemWr  = 19;
    localparam int CMbrAcc = 20;
    localparam int CHalt   = 21;

    // Where the final execute state of every instruction hands over to.
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
    localparam state_e StDone = StPause;
`else
    localparam state_e StDone = StFetch1;
`endif

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [21:0] cw;
    logic        op_illegal;

    assign op_illegal = (opcode_i > OpHalt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
            op_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        cw           = '0;
        halted_o     = 1'b0;
        illegal_op_o = 1'b0;
        case (state_q)
            StBoot: state_d = StFetch1;
            StFetch1: begin
                cw[CMarPc] = 1'b1;
                state_d    = StFetch2;
            end
            StFetch2: begin
                cw[CMbrMem] = 1'b1;
                cw[CPcInc]  = 1'b1;
                state_d     = StFetch3;
            end
            StFetch3: begin
                cw[CIrMbr]  = 1'b1;
                cw[CMarMbr] = 1'b1;
                state_d     = StDecode;
            end
            StDecode: begin
                op_d         = opcode_i;
                illegal_op_o = op_illegal;
                if (opcode_i == OpHalt || (ILLEGAL_HALT && op_illegal)) begin
                    state_d = StHalt;
                end else begin
                    state_d = StEx1;
                end
            end
            StEx1: begin
                case (op_q)
                    OpStore: begin
                        cw[CMbrAcc] = 1'b1;
                        state_d     = StEx2;
                    end
                    OpLoad, OpAdd, OpSub: begin
                        cw[CMbrMem] = 1'b1;
                        state_d     = StEx2;
                    end
                    OpJmpgez: begin
                        cw[CPcMbr] = ~acc_neg_i;
                        state_d    = StDone;
                    end
                    OpJmp: begin
                        cw[CPcMbr] = 1'b1;
                        state_d    = StDone;
                    end
                    // NOP and undefined opcodes that did not halt.
                    default: state_d = StDone;
                endcase
            end
            StEx2: begin
                if (op_q == OpStore) begin
                    cw[CMemWr] = 1'b1;
                    state_d    = StDone;
                end else begin
                    cw[CBrMbr] = 1'b1;
                    state_d    = StEx3;
                end
            end
            StEx3: begin
                case (op_q)
                    OpLoad:  cw[CAccBr]  = 1'b1;
                    OpAdd:   cw[CAccAdd] = 1'b1;
                    OpSub:   cw[CAccSub] = 1'b1;
                    default: cw = '0;
                endcase
                state_d = StDone;
            end
            StHalt: begin
                cw[CHalt] = 1'b1;
                halted_o  = 1'b1;
            end
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
            StPause: begin
                if (step_i) begin
                    state_d = StFetch1;
                end
            end
`endif
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        control_signal_o       = '0;
        control_signal_o[21:0] = cw;
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction vector table, randomized
// instruction stream, halt, illegal-opcode and asynchronous-reset sequences.
module tb_control_unit;

    logic        clk;
    logic        rst_n;
    logic        rst_h_n;
    logic        acc_neg;
    logic        step;
    logic [7:0]  opcode;
    logic [7:0]  opcode_h;
    logic [31:0] cs, cs_h;
    logic [3:0]  st, st_h;
    logic        halted, halted_h, ill, ill_h;

    control_unit #(.ILLEGAL_HALT(1'b0), .CW_WIDTH(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        .step_i           (step),
`endif
        .opcode_i         (opcode),
        .acc_neg_i        (acc_neg),
        .control_signal_o (cs),
        .state_o          (st),
        .halted_o         (halted),
        .illegal_op_o     (ill)
    );

    control_unit #(.ILLEGAL_HALT(1'b1), .CW_WIDTH(32)) dut_h (
        .clk              (clk),
        .rst_n            (rst_h_n),
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        .step_i           (1'b0),
`endif
        .opcode_i         (opcode_h),
        .acc_neg_i        (1'b0),
        .control_signal_o (cs_h),
        .state_o          (st_h),
        .halted_o         (halted_h),
        .illegal_op_o     (ill_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic        neg_dec;
        logic        neg_ex;
        logic        ill;
        int          n_ex;
        logic [31:0] ex0;
        logic [31:0] ex1;
        logic [31:0] ex2;
    } vec_t;

    typedef struct {
        logic [31:0] cw;
        logic [3:0]  st;
        logic        halt;
        logic        ill;
    } exp_t;

    localparam int NVec = 13;
    vec_t vec [NVec];
    exp_t sb_q [$];
    int   checks;
    int   failures;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Push the expectation for this cycle, compare at the falling edge, return just after
    // the next rising edge so the caller can drive inputs for the following cycle.
    task automatic expect_cycle(input string tag, input logic [31:0] cw, input logic [3:0] s,
                                input logic h, input logic il);
        exp_t e;
        e.cw = cw; e.st = s; e.halt = h; e.ill = il;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({tag, ".cw"}, cs, e.cw);
        chk({tag, ".state"}, {28'h0, st}, {28'h0, e.st});
        chk({tag, ".halted"}, {31'h0, halted}, {31'h0, e.halt});
        chk({tag, ".illegal"}, {31'h0, ill}, {31'h0, e.ill});
        chk({tag, ".mbr_excl"}, {31'h0, cs[3] & (cs[19] | cs[20])}, 32'h0);
        chk({tag, ".wr_excl"}, {31'h0, cs[19] & cs[20]}, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        string tag;
        logic [31:0] w;
        tag = $sformatf("op%02h", v.op);
        opcode  = v.op;
        acc_neg = v.neg_dec;
        expect_cycle({tag, ".f1"}, 32'h2, 4'd1, 1'b0, 1'b0);
        expect_cycle({tag, ".f2"}, 32'h9, 4'd2, 1'b0, 1'b0);
        expect_cycle({tag, ".f3"}, 32'h14, 4'd3, 1'b0, 1'b0);
        expect_cycle({tag, ".dec"}, 32'h0, 4'd4, 1'b0, v.ill);
        acc_neg = v.neg_ex;
        for (int i = 0; i < v.n_ex; i++) begin
            w = (i == 0) ? v.ex0 : (i == 1) ? v.ex1 : v.ex2;
            expect_cycle($sformatf("%s.ex%0d", tag, i + 1), w, 4'(5 + i), 1'b0, 1'b0);
        end
`ifdef CONTROL_UNIT_SINGLE_STEP_EN
        step = 1'b0;
        expect_cycle({tag, ".pause0"}, 32'h0, 4'd9, 1'b0, 1'b0);
        expect_cycle({tag, ".pause1"}, 32'h0, 4'd9, 1'b0, 1'b0);
        step = 1'b1;
        expect_cycle({tag, ".pause2"}, 32'h0, 4'd9, 1'b0, 1'b0);
        step = 1'b0;
`endif
    endtask

    initial begin
        logic [3:0] h_st  [7];
        logic       h_ill [7];
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        rst_h_n  = 1'b0;
        opcode   = 8'h00;
        opcode_h = 8'hAB;
        acc_neg  = 1'b0;
        step     = 1'b0;

        //          op     dec   ex    ill   n  ex0          ex1         ex2
        vec[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1, 32'h0,      32'h0,      32'h0};
        vec[1]  = '{8'h01, 1'b0, 1'b0, 1'b0, 2, 32'h100000, 32'h80000,  32'h0};
        vec[2]  = '{8'h02, 1'b0, 1'b0, 1'b0, 3, 32'h8,      32'h40,     32'h400};
        vec[3]  = '{8'h03, 1'b0, 1'b0, 1'b0, 3, 32'h8,      32'h40,     32'h100};
        vec[4]  = '{8'h04, 1'b1, 1'b1, 1'b0, 3, 32'h8,      32'h40,     32'h200};
        vec[5]  = '{8'h05, 1'b0, 1'b0, 1'b0, 1, 32'h20,     32'h0,      32'h0};
        vec[6]  = '{8'h05, 1'b1, 1'b1, 1'b0, 1, 32'h0,      32'h0,      32'h0};
        vec[7]  = '{8'h05, 1'b1, 1'b0, 1'b0, 1, 32'h20,     32'h0,      32'h0};
        vec[8]  = '{8'h05, 1'b0, 1'b1, 1'b0, 1, 32'h0,      32'h0,      32'h0};
        vec[9]  = '{8'h06, 1'b1, 1'b1, 1'b0, 1, 32'h20,     32'h0,      32'h0};
        vec[10] = '{8'hAB, 1'b0, 1'b0, 1'b1, 1, 32'h0,      32'h0,      32'h0};
        vec[11] = '{8'h08, 1'b0, 1'b0, 1'b1, 1, 32'h0,      32'h0,      32'h0};
        vec[12] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1, 32'h0,      32'h0,      32'h0};

        repeat (2) @(posedge clk);
        #1;
        expect_cycle("in_reset", 32'h0, 4'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        expect_cycle("boot", 32'h0, 4'd0, 1'b0, 1'b0);

        // Opcode stuck at NOP: 5-cycle repeating pattern.
        run_vec(vec[0]);
        run_vec(vec[0]);

        for (int i = 0; i < NVec; i++) run_vec(vec[i]);
        for (int n = 0; n < 200; n++) run_vec(vec[$urandom_range(0, NVec - 1)]);

        // Asynchronous reset in the middle of ADD EX2.
        opcode  = 8'h03;
        acc_neg = 1'b0;
        expect_cycle("rst.f1", 32'h2, 4'd1, 1'b0, 1'b0);
        expect_cycle("rst.f2", 32'h9, 4'd2, 1'b0, 1'b0);
        expect_cycle("rst.f3", 32'h14, 4'd3, 1'b0, 1'b0);
        expect_cycle("rst.dec", 32'h0, 4'd4, 1'b0, 1'b0);
        expect_cycle("rst.ex1", 32'h8, 4'd5, 1'b0, 1'b0);
        #2;
        chk("rst.ex2_before", cs, 32'h40);
        rst_n = 1'b0;
        #1;
        chk("rst.async_cw", cs, 32'h0);
        chk("rst.async_state", {28'h0, st}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        expect_cycle("rst.boot", 32'h0, 4'd0, 1'b0, 1'b0);
        run_vec(vec[3]);

        // HALT is absorbing.
        opcode = 8'h07;
        expect_cycle("halt.f1", 32'h2, 4'd1, 1'b0, 1'b0);
        expect_cycle("halt.f2", 32'h9, 4'd2, 1'b0, 1'b0);
        expect_cycle("halt.f3", 32'h14, 4'd3, 1'b0, 1'b0);
        expect_cycle("halt.dec", 32'h0, 4'd4, 1'b0, 1'b0);
        opcode = 8'h00;
        step   = 1'b1;
        for (int i = 0; i < 100; i++) expect_cycle("halt.hold", 32'h200000, 4'd8, 1'b1, 1'b0);
        step = 1'b0;

        // Undefined opcode with ILLEGAL_HALT=1 halts after its DECODE pulse.
        h_st  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd8};
        h_ill = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst_h_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("ih.state%0d", i), {28'h0, st_h}, {28'h0, h_st[i]});
            chk($sformatf("ih.ill%0d", i), {31'h0, ill_h}, {31'h0, h_ill[i]});
            chk($sformatf("ih.halted%0d", i), {31'h0, halted_h}, {31'h0, h_st[i] == 4'd8});
            chk($sformatf("ih.cw%0d", i), cs_h, (h_st[i] == 4'd8) ? 32'h200000 :
                (h_st[i] == 4'd1) ? 32'h2 : (h_st[i] == 4'd2) ? 32'h9 :
                (h_st[i] == 4'd3) ? 32'h14 : 32'h0);
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
